sync_set_clear_bank: RTL and testbench



---
 rtl/sync_bank_pkg.sv | 22 ++
 rtl/sync_set_clear_reg.sv | 57 +++++
 rtl/sync_set_clear_bank.sv | 96 +++++++++
 tb/tb_sync_set_clear_bank.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_bank_pkg.sv
// Shared types and helpers for the synchronous set/clear register bank.
// Holds the control FSM state type and the hold-off counter width function.
package sync_bank_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Counter must hold values up to HOLD_CYCLES and never collapse to zero width.
    function automatic int cnt_width(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles + 1);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/sync_set_clear_reg.sv
// One channel register: synchronous global clear, then clear > preset > load > hold
// while enabled, plus a registered flag marking a change of value.
module sync_set_clear_reg
    import sync_bank_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] CLEAR_VALUE  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             ch_clear,
    input  logic             ch_preset,
    input  logic             ch_load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             changed
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             changed_r;

    // Per-channel command priority, applied only while the bank is running.
    always_comb begin
        q_next_s = q_r;
        if (enable) begin
            if (ch_clear) begin
                q_next_s = CLEAR_VALUE;
            end else if (ch_preset) begin
                q_next_s = PRESET_VALUE;
            end else if (ch_load) begin
                q_next_s = data;
            end else begin
                q_next_s = q_r;
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Value register and change flag; global clear overrides every command.
    always_ff @(posedge clock) begin
        if (clear) begin
            q_r       <= CLEAR_VALUE;
            changed_r <= (q_r != CLEAR_VALUE);
        end else begin
            q_r       <= q_next_s;
            changed_r <= (q_next_s != q_r);
        end
    end

    assign q       = q_r;
    assign changed = changed_r;

endmodule

// File: rtl/sync_set_clear_bank.sv
// Bank of CHANNELS clear/preset/load registers behind a reset -> hold-off -> run
// control FSM; channel commands take effect only once ready is already high.
module sync_set_clear_bank
    import sync_bank_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               CHANNELS     = 4,
    parameter int               HOLD_CYCLES  = 4,
    parameter logic [WIDTH-1:0] CLEAR_VALUE  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       ch_clear,
    input  logic [CHANNELS-1:0]       ch_preset,
    input  logic [CHANNELS-1:0]       ch_load,
    input  logic [CHANNELS*WIDTH-1:0] data,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       changed,
    output logic                      ready
);

    localparam int               CNT_W       = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
    localparam state_t           AFTER_RESET = (HOLD_CYCLES == 0) ? RUN : HOLD;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             ready_r;
    logic             accept_s;

    // Next-state and hold-off counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            RESET: begin
                state_next_s = AFTER_RESET;
                cnt_next_s   = {CNT_W{1'b0}};
            end
            HOLD: begin
                cnt_next_s = cnt_r + CNT_W'(1);
                if (cnt_r == HOLD_LAST) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HOLD;
                end
            end
            RUN: begin
                state_next_s = RUN;
            end
            default: begin
                state_next_s = RESET;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and ready registers; clear has absolute priority.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= RESET;
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (state_next_s == RUN);
        end
    end

    // Commands are honoured only on edges where ready is already visible.
    assign accept_s = ready_r;
    assign ready    = ready_r;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        sync_set_clear_reg #(
            .WIDTH       (WIDTH),
            .CLEAR_VALUE (CLEAR_VALUE),
            .PRESET_VALUE(PRESET_VALUE)
        ) u_reg (
            .clock    (clock),
            .clear    (clear),
            .enable   (accept_s),
            .ch_clear (ch_clear[i]),
            .ch_preset(ch_preset[i]),
            .ch_load  (ch_load[i]),
            .data     (data[i*WIDTH +: WIDTH]),
            .q        (q[i*WIDTH +: WIDTH]),
            .changed  (changed[i])
        );
    end

endmodule

// File: tb/tb_sync_set_clear_bank.sv
// Scoreboard bench: three builds (default, zero hold-off, 1-bit single channel);
// expected values are queued when stimulus is driven and compared after the edge.
module tb_sync_set_clear_bank;

    typedef struct {
        logic [31:0] q;
        logic [3:0]  changed;
        logic        ready;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear_a = 1'b1, ready_a;
    logic [3:0]  ch_clear_a = 4'h0, ch_preset_a = 4'h0, ch_load_a = 4'h0, changed_a;
    logic [31:0] data_a = 32'h0, q_a;

    logic        clear_b = 1'b1, ready_b;
    logic [3:0]  ch_clear_b = 4'h0, ch_preset_b = 4'h0, ch_load_b = 4'h0, changed_b;
    logic [31:0] data_b = 32'h0, q_b;

    logic clear_c = 1'b1, ch_clear_c = 1'b0, ch_preset_c = 1'b0, ch_load_c = 1'b0;
    logic data_c = 1'b0, q_c, changed_c, ready_c;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    sync_set_clear_bank #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(4)) dut (
        .clock(clock), .clear(clear_a), .ch_clear(ch_clear_a), .ch_preset(ch_preset_a),
        .ch_load(ch_load_a), .data(data_a), .q(q_a), .changed(changed_a), .ready(ready_a));

    sync_set_clear_bank #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(0)) dut_h0 (
        .clock(clock), .clear(clear_b), .ch_clear(ch_clear_b), .ch_preset(ch_preset_b),
        .ch_load(ch_load_b), .data(data_b), .q(q_b), .changed(changed_b), .ready(ready_b));

    sync_set_clear_bank #(.WIDTH(1), .CHANNELS(1), .HOLD_CYCLES(2)) dut_w1 (
        .clock(clock), .clear(clear_c), .ch_clear(ch_clear_c), .ch_preset(ch_preset_c),
        .ch_load(ch_load_c), .data(data_c), .q(q_c), .changed(changed_c), .ready(ready_c));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] q, input logic [3:0] chg, input logic rdy);
        exp_t x;
        x.q = q; x.changed = chg; x.ready = rdy;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        clear_a = 1'b1;
        repeat (2) step();
        push(32'h0, 4'h0, 1'b0);
        step();
        e = sb.pop_front();
        checks++;
        if ({q_a, changed_a, ready_a} !== {e.q, e.changed, e.ready}) begin
            errors++;
            $display("FAIL reset: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                     q_a, changed_a, ready_a, e.q, e.changed, e.ready);
        end
    endtask

    task automatic test_hold();
        clear_a   = 1'b0;
        ch_load_a = 4'hF;
        data_a    = 32'hAAAA_AAAA;
        for (int i = 0; i < 5; i++) begin
            push(32'h0, 4'h0, (i == 4));
            step();
            e = sb.pop_front();
            checks++;
            if ({q_a, changed_a, ready_a} !== {e.q, e.changed, e.ready}) begin
                errors++;
                $display("FAIL hold_%0d: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                         i, q_a, changed_a, ready_a, e.q, e.changed, e.ready);
            end
        end
        ch_load_a = 4'h0;
    endtask

    task automatic test_priority();
        ch_clear_a  = 4'b0001;
        ch_preset_a = 4'b0011;
        ch_load_a   = 4'b0111;
        data_a      = 32'h005A_5A5A;
        push(32'h005A_FF00, 4'b0110, 1'b1);
        step();
        ch_clear_a = 4'h0; ch_preset_a = 4'h0; ch_load_a = 4'h0;
        e = sb.pop_front();
        checks++;
        if ({q_a, changed_a, ready_a} !== {e.q, e.changed, e.ready}) begin
            errors++;
            $display("FAIL priority: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                     q_a, changed_a, ready_a, e.q, e.changed, e.ready);
        end
    endtask

    task automatic test_changed();
        ch_load_a = 4'b1000;
        data_a    = 32'h3300_0000;
        push(32'h335A_FF00, 4'b1000, 1'b1);
        push(32'h335A_FF00, 4'b0000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            e = sb.pop_front();
            checks++;
            if ({q_a, changed_a, ready_a} !== {e.q, e.changed, e.ready}) begin
                errors++;
                $display("FAIL changed_%0d: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                         i, q_a, changed_a, ready_a, e.q, e.changed, e.ready);
            end
        end
        ch_load_a = 4'h0;
    endtask

    task automatic test_mid_reset();
        clear_a   = 1'b1;
        ch_load_a = 4'hF;
        data_a    = 32'h1111_1111;
        push(32'h0, 4'b1110, 1'b0);
        push(32'h0, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            e = sb.pop_front();
            checks++;
            if ({q_a, changed_a, ready_a} !== {e.q, e.changed, e.ready}) begin
                errors++;
                $display("FAIL mid_reset_%0d: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                         i, q_a, changed_a, ready_a, e.q, e.changed, e.ready);
            end
        end
        ch_load_a = 4'h0;
        clear_a   = 1'b0;
        repeat (4) step();
        push(32'h0, 4'h0, 1'b1);
        step();
        e = sb.pop_front();
        checks++;
        if ({q_a, changed_a, ready_a} !== {e.q, e.changed, e.ready}) begin
            errors++;
            $display("FAIL rerun: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                     q_a, changed_a, ready_a, e.q, e.changed, e.ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[4] = '{8'h01, 8'h02, 8'h02, 8'h80};
        logic       chg[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        ch_load_a = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            data_a = {24'h0, vals[i]};
            push({24'h0, vals[i]}, {3'b000, chg[i]}, 1'b1);
            step();
            e = sb.pop_front();
            checks++;
            if ({q_a, changed_a, ready_a} !== {e.q, e.changed, e.ready}) begin
                errors++;
                $display("FAIL b2b_%0d: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                         i, q_a, changed_a, ready_a, e.q, e.changed, e.ready);
            end
        end
        ch_load_a = 4'h0;
    endtask

    task automatic test_hold_zero();
        push(32'h0, 4'h0, 1'b0);
        push(32'h0, 4'h0, 1'b1);
        push(32'h0000_0077, 4'b0001, 1'b1);
        push(32'h0000_0077, 4'b0000, 1'b1);
        step();
        clear_b   = 1'b0;
        ch_load_b = 4'b0001;
        data_b    = 32'h0000_0077;
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            checks++;
            if ({q_b, changed_b, ready_b} !== {e.q, e.changed, e.ready}) begin
                errors++;
                $display("FAIL hold_zero_%0d: got q=%h chg=%b rdy=%b expected q=%h chg=%b rdy=%b",
                         i, q_b, changed_b, ready_b, e.q, e.changed, e.ready);
            end
            step();
        end
        ch_load_b = 4'h0;
    endtask

    task automatic test_sweep();
        logic m_q = 1'b0, m_ready = 1'b0, nq;
        int   m_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            clear_c     = ($urandom_range(0, 19) == 0);
            ch_clear_c  = ($urandom_range(0, 3) == 0);
            ch_preset_c = ($urandom_range(0, 3) == 0);
            ch_load_c   = ($urandom_range(0, 1) == 0);
            data_c      = 1'($urandom_range(0, 1));
            if (clear_c) begin
                nq = 1'b0;
                m_cnt = 0;
            end else begin
                nq = m_q;
                if (m_ready) begin
                    if (ch_clear_c)       nq = 1'b0;
                    else if (ch_preset_c) nq = 1'b1;
                    else if (ch_load_c)   nq = data_c;
                end
                if (m_cnt < 10) m_cnt++;
            end
            push({31'h0, nq}, {3'b000, (nq != m_q)}, (!clear_c && m_cnt >= 3));
            m_q     = nq;
            m_ready = (!clear_c && m_cnt >= 3);
            step();
            e = sb.pop_front();
            checks++;
            if ({q_c, changed_c, ready_c} !== {e.q[0], e.changed[0], e.ready}) begin
                errors++;
                $display("FAIL sweep_%0d: got q=%b chg=%b rdy=%b expected q=%b chg=%b rdy=%b",
                         i, q_c, changed_c, ready_c, e.q[0], e.changed[0], e.ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_priority();
        test_changed();
        test_mid_reset();
        test_back_to_back();
        test_hold_zero();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
